// File: rtl/carry_resolve_pkg.sv
// Shared parameters, operand/result types and FSM states for the carry resolver.
package carry_resolve_pkg;

    localparam int LIMB_W  = 8;
    localparam int CARRY_W = 3;
    localparam int ADD_DIV = 4;
    localparam int RLIMB_W = LIMB_W + CARRY_W;

    // Redundant operand: ADD_DIV limbs, each with CARRY_W bits of carry headroom.
    typedef logic [ADD_DIV-1:0][RLIMB_W-1:0] redundant_poly_L1;

    // Carry-resolved result: plain unsigned integer of ADD_DIV*LIMB_W bits.
    typedef logic [ADD_DIV*LIMB_W-1:0] uint_Mtilde2_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/carry_resolve_limb_adder.sv
// One redundant limb plus incoming carry, split into the radix digit and the
// carry passed to the next limb.
module limb_adder #(
    parameter int LIMB_W  = 8,
    parameter int CARRY_W = 3
) (
    input  logic [LIMB_W+CARRY_W-1:0] limb,
    input  logic [CARRY_W:0]          cin,
    output logic [LIMB_W-1:0]         sum,
    output logic [CARRY_W:0]          cout
);

    localparam int FULL_W = LIMB_W + CARRY_W + 1;

    // Max limb plus max carry still fits in FULL_W bits, so the carry-out
    // never needs more than CARRY_W+1 bits.
    logic [FULL_W-1:0] full;

    assign full = FULL_W'(limb) + FULL_W'(cin);
    assign sum  = full[LIMB_W-1:0];
    assign cout = full[FULL_W-1:LIMB_W];

endmodule

// File: rtl/carry_resolve.sv
// Serial carry resolver: walks a redundant operand one limb per cycle,
// propagating carries upward, and presents the normalised integer plus an
// overflow flag for the carry left over after the top limb.
//
//   state | meaning
//   IDLE  | ready for an operand
//   RUN   | resolving limb idx
//   DONE  | result valid, waiting for out_ready
module carry_resolve #(
    parameter int N_LIMB  = carry_resolve_pkg::ADD_DIV,
    parameter int LIMB_W  = carry_resolve_pkg::LIMB_W,
    parameter int CARRY_W = carry_resolve_pkg::CARRY_W
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [N_LIMB-1:0][LIMB_W+CARRY_W-1:0]   din,
    input  logic [2:0]                              tag_in,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [N_LIMB*LIMB_W-1:0]                dout,
    output logic [2:0]                              tag_out,
    output logic                                    overflow
);

    import carry_resolve_pkg::*;

    localparam int RW    = LIMB_W + CARRY_W;
    localparam int IDX_W = (N_LIMB > 1) ? $clog2(N_LIMB) : 1;

    state_t                         state;
    state_t                         state_nx;
    logic [N_LIMB-1:0][RW-1:0]      limbs;
    logic [N_LIMB-1:0][LIMB_W-1:0]  res;
    logic [CARRY_W:0]               carry;
    logic [IDX_W-1:0]               idx;
    logic [2:0]                     tag;
    logic                           ovf;
    logic                           accept;
    logic                           step;
    logic                           last;
    logic [LIMB_W-1:0]              sum;
    logic [CARRY_W:0]               cout;

    assign last     = (idx == IDX_W'(N_LIMB - 1));
    assign dout     = res;
    assign tag_out  = tag;
    assign overflow = ovf;

    limb_adder #(
        .LIMB_W  (LIMB_W),
        .CARRY_W (CARRY_W)
    ) u_limb_adder (
        .limb (limbs[idx]),
        .cin  (carry),
        .sum  (sum),
        .cout (cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and handshake outputs; one limb per RUN cycle gives fixed latency.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture and limb-by-limb carry propagation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limbs <= '0;
            res   <= '0;
            carry <= '0;
            idx   <= '0;
            tag   <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            limbs <= din;
            tag   <= tag_in;
            res   <= '0;
            carry <= '0;
            idx   <= '0;
            ovf   <= 1'b0;
        end else if (step) begin
            res[idx] <= sum;
            carry    <= cout;
            idx      <= idx + 1'b1;
            if (last) begin
                ovf <= |cout;
            end
        end
    end

endmodule

// File: tb/tb_carry_resolve.sv
// Randomised and directed bench for carry_resolve (4 limbs x 8 bits, 3 carry bits).
module tb_carry_resolve;

    typedef logic [3:0][10:0] poly_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    poly_t       din;
    logic [2:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dout;
    logic [2:0]  tag_out;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    carry_resolve #(
        .N_LIMB  (4),
        .LIMB_W  (8),
        .CARRY_W (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .tag_out   (tag_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter used for latency and spacing checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: the redundant operand is just sum(limb_i * 2^(8i)).
    function automatic void ref_model(input poly_t d, output logic [31:0] r, output logic o);
        longint unsigned total;
        total = 0;
        for (int i = 0; i < 4; i++) begin
            total += longint'(d[i]) << (8 * i);
        end
        r = total[31:0];
        o = (total >> 32) != 0;
    endfunction

    function automatic poly_t rand_poly();
        poly_t p;
        for (int i = 0; i < 4; i++) begin
            p[i] = 11'($urandom_range(0, 2047));
        end
        return p;
    endfunction

    // One transaction: present operand, wait for the result, optionally stall
    // out_ready for 'hold' cycles, then release. Returns the out_valid cycle.
    task automatic do_op(input poly_t d, input logic [2:0] t, input int hold,
                         input bit use_fix, input logic [32:0] fix, output int ov_cyc);
        logic [31:0] er;
        logic        eo;
        int          acc;
        int          n;
        ref_model(d, er, eo);
        if (use_fix) begin
            er = fix[31:0];
            eo = fix[32];
        end
        @(negedge clk);
        out_ready = 1'b0;
        din       = d;
        tag_in    = t;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready", in_ready, 1);
        acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din      = rand_poly();
        tag_in   = 3'($urandom);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            in_valid = 1'($urandom_range(0, 1));
            din      = rand_poly();
            tag_in   = 3'($urandom);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        ov_cyc   = cyc;
        check("out_valid", out_valid, 1);
        check("latency", 64'(cyc - acc), 5);
        check("dout", dout, er);
        check("overflow", overflow, eo);
        check("tag_out", tag_out, t);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            din      = rand_poly();
            tag_in   = 3'($urandom);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_dout", dout, er);
            check("hold_tag", tag_out, t);
            check("hold_ovf", overflow, eo);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int    oc;
        int    prev;
        int    n;
        poly_t p;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        tag_in    = '0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_tag", tag_out, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;

        // Directed cases.
        do_op({11'h000, 11'h000, 11'h0FF, 11'h1FF}, 3'd3, 0, 1'b1, {1'b0, 32'h000100FF}, oc);
        do_op({11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF}, 3'd5, 0, 1'b1, {1'b1, 32'h070706FF}, oc);
        do_op({11'h100, 11'h000, 11'h000, 11'h000}, 3'd6, 0, 1'b1, {1'b1, 32'h00000000}, oc);

        // Stall in DONE with in_valid pulses that must be ignored.
        do_op(rand_poly(), 3'd2, 5, 1'b0, '0, oc);
        @(negedge clk);
        check("handoff_valid", out_valid, 0);
        check("handoff_ready", in_ready, 1);

        // Abort in the middle of RUN.
        @(negedge clk);
        out_ready = 1'b0;
        din       = {11'h123, 11'h456, 11'h789, 11'h0AB};
        tag_in    = 3'd7;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_ready", in_ready, 1);
        check("abort_dout", dout, 0);
        check("abort_tag", tag_out, 0);
        check("abort_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("post_rst_no_result", 64'(n), 0);
        do_op(rand_poly(), 3'd1, 0, 1'b0, '0, oc);

        // Back-to-back random operands with out_ready held high.
        prev = 0;
        for (int k = 0; k < 24; k++) begin
            p = rand_poly();
            if (k == 0) p = {11'h7FF, 11'h000, 11'h7FF, 11'h000};
            do_op(p, 3'($urandom), 0, 1'b0, '0, oc);
            if (k > 0) check("spacing", 64'(oc - prev), 6);
            prev = oc;
        end

        @(negedge clk);
        out_ready = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
